layer_sequencer: RTL and testbench

Sequencer that drives one fully-connected layer pass through `output_memory_manager`. On `start` it clears the manager and streams every (z, m) operand pair from the input-activation RAM and the weight RAM, one element per cycle, neuron-minor order (8 neurons per input). It then holds `last_element` through write-back until the manager reports `finished`, and signals `done`. It sits between the top-level layer controller and the manager/RAM datapath.

---
 rtl/layer_sequencer_if.sv | 37 +++
 rtl/layer_sequencer.sv | 109 ++++++++++
 tb/tb_layer_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// rtl/layer_sequencer_if.sv - operand RAM and output manager bus of the layer sequencer
interface layer_sequencer_if #(
    parameter int IA_W = 4,
    parameter int WA_W = 7
);
    logic [IA_W-1:0] input_ram_address;
    logic            input_ram_enable;
    logic [15:0]     input_ram_data;
    logic [WA_W-1:0] weight_ram_address;
    logic            weight_ram_enable;
    logic [15:0]     weight_ram_data;
    logic            mgr_clear;
    logic            mgr_en;
    logic [15:0]     active_z;
    logic [15:0]     active_m;
    logic            next_element;
    logic            last_element;
    logic            mgr_finished;

    modport master (
        output input_ram_address, input_ram_enable,
        input  input_ram_data,
        output weight_ram_address, weight_ram_enable,
        input  weight_ram_data,
        output mgr_clear, mgr_en, active_z, active_m, next_element, last_element,
        input  mgr_finished
    );

    modport slave (
        input  input_ram_address, input_ram_enable,
        output input_ram_data,
        input  weight_ram_address, weight_ram_enable,
        output weight_ram_data,
        input  mgr_clear, mgr_en, active_z, active_m, next_element, last_element,
        output mgr_finished
    );
endinterface

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - streams every (z, m) operand pair of one layer pass into the output manager
module layer_sequencer #(
    parameter int N_INPUTS = 16,
    parameter int IA_W     = 4,
    parameter int WA_W     = 7,
    parameter int WDOG     = 32
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                pause,
    layer_sequencer_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic                error
);
    typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, WB, DONE} state_t;

    localparam int N_ELEM = 8 * N_INPUTS;
    localparam int WD_W   = $clog2(WDOG + 1);
    localparam logic [WA_W-1:0] LAST_ELEM = WA_W'(N_ELEM - 1);
    localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG - 1);

    state_t          state;
    logic [WA_W-1:0] elem;
    logic [WD_W-1:0] wdog;
    logic            issue;

    // Flat element index: weight address is i*8+j, so z address is simply elem/8.
    assign issue                  = (state == STREAM) && !pause;
    assign bus.input_ram_enable   = issue;
    assign bus.weight_ram_enable  = issue;
    assign bus.weight_ram_address = elem;
    assign bus.input_ram_address  = IA_W'(elem >> 3);
    assign bus.active_z           = bus.input_ram_data;
    assign bus.active_m           = bus.weight_ram_data;

    always_ff @(posedge clock) begin
        if (clear) begin
            state            <= IDLE;
            elem             <= '0;
            wdog             <= '0;
            bus.mgr_clear    <= 1'b0;
            bus.mgr_en       <= 1'b0;
            bus.next_element <= 1'b0;
            bus.last_element <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            // RAM data lands one cycle after the read strobe.
            bus.next_element <= issue;
            bus.mgr_clear    <= 1'b0;
            done             <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= CLR;
                        bus.mgr_clear <= 1'b1;
                        busy          <= 1'b1;
                        error         <= 1'b0;
                    end
                end
                CLR: begin
                    elem  <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (!pause) begin
                        if (elem == LAST_ELEM) begin
                            elem  <= '0;
                            state <= DRAIN;
                        end else begin
                            elem <= elem + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state            <= WB;
                    bus.last_element <= 1'b1;
                    bus.mgr_en       <= 1'b1;
                    wdog             <= '0;
                end
                WB: begin
                    if (bus.mgr_finished) begin
                        state            <= DONE;
                        done             <= 1'b1;
                        bus.last_element <= 1'b0;
                        bus.mgr_en       <= 1'b0;
                    end else if (wdog == WDOG_LAST) begin
                        // Write-back never completed: abandon the pass without done.
                        state            <= IDLE;
                        error            <= 1'b1;
                        busy             <= 1'b0;
                        bus.last_element <= 1'b0;
                        bus.mgr_en       <= 1'b0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - randomized scoreboard bench for layer_sequencer
module tb_layer_sequencer;
    localparam int N    = 2;
    localparam int IA_W = 1;
    localparam int WA_W = 4;
    localparam int WDOG = 32;
    localparam int NE   = 8 * N;

    logic clock = 1'b0;
    logic clear = 1'b1;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic busy, done, error;

    layer_sequencer_if #(.IA_W(IA_W), .WA_W(WA_W)) bus ();

    layer_sequencer #(.N_INPUTS(N), .IA_W(IA_W), .WA_W(WA_W), .WDOG(WDOG)) dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .pause (pause),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clock = ~clock;

    logic [15:0] zram [N];
    logic [15:0] wram [NE];
    logic [15:0] zq = '0;
    logic [15:0] wq = '0;

    always @(posedge clock) begin
        if (bus.input_ram_enable)  zq <= zram[bus.input_ram_address];
        if (bus.weight_ram_enable) wq <= wram[bus.weight_ram_address];
    end
    assign bus.input_ram_data  = zq;
    assign bus.weight_ram_data = wq;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0]       exp_q [$];
    longint unsigned   acc_q [$];
    longint unsigned   acc [8];
    logic [31:0]       mon_e;
    int issue_idx = 0, ne_idx = 0, c1 = 0, done_cyc = 0, fin_cyc = 0;
    int done_cnt = 0, clr_cnt = 0, le_cnt = 0, fin_delay = 0;
    bit timing_pass = 0, chain_mode = 0, chain_armed = 0, fin_sent = 0;
    bit prev_busy = 0, prev_le = 0, prev_done = 0, first_ne_seen = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents data.
    always @(negedge clock) begin
        if (!clear) begin
            if (busy && !prev_busy) begin
                c1 = cyc;
                check("error_cleared_on_start", error, 0);
                if (chain_mode && chain_armed) check("chain_restart_gap", cyc - done_cyc, 2);
                first_ne_seen = 0;
                le_cnt = 0;
            end
            if (bus.mgr_clear) begin
                clr_cnt++;
                issue_idx = 0;
                ne_idx = 0;
                foreach (acc[j]) acc[j] = 0;
            end
            if (bus.weight_ram_enable) begin
                check("weight_addr", bus.weight_ram_address, issue_idx);
                check("input_addr", bus.input_ram_address, issue_idx / 8);
                check("input_enable", bus.input_ram_enable, 1);
                issue_idx++;
            end
            if (bus.next_element) begin
                if (timing_pass && !first_ne_seen) check("first_element_cycle", cyc - c1, 2);
                first_ne_seen = 1;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_element: got pair with empty queue, required none (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("operand_pair", {bus.active_z, bus.active_m}, mon_e);
                end
                acc[ne_idx % 8] += longint'(bus.active_z) * longint'(bus.active_m);
                ne_idx++;
            end
            if (bus.last_element) begin
                if (!prev_le && timing_pass) check("last_element_cycle", cyc - c1, 2 + NE);
                le_cnt++;
            end
            if (done) begin
                check("done_width", prev_done, 0);
                check("elements_per_pass", ne_idx, NE);
                check("done_after_finished", cyc - fin_cyc, 1);
                check("last_element_low_in_done", bus.last_element, 0);
                for (int j = 0; j < 8; j++) begin
                    if (acc_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL neuron_sum: got done with no expected sums, required none");
                    end else begin
                        check("neuron_sum", acc[j], acc_q.pop_front());
                    end
                end
                done_cnt++;
                done_cyc = cyc;
                if (chain_mode) chain_armed = 1;
            end
            if (prev_done) check("busy_low_after_done", busy, 0);
        end
        prev_busy = busy;
        prev_le   = bus.last_element;
        prev_done = done;
    end

    task automatic load_rams();
        foreach (zram[i]) zram[i] = 16'($urandom);
        foreach (wram[k]) wram[k] = 16'($urandom);
    endtask

    // Reference: element k pairs z[k/8] with w[k]; neuron j sums z[i]*w[8i+j].
    task automatic push_expect(bit with_acc);
        longint unsigned s;
        for (int k = 0; k < NE; k++) exp_q.push_back({zram[k / 8], wram[k]});
        if (with_acc) begin
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int i = 0; i < N; i++) s += longint'(zram[i]) * longint'(wram[i * 8 + j]);
                acc_q.push_back(s);
            end
        end
    endtask

    task automatic respond(bit fin_en);
        bus.mgr_finished = 1'b0;
        if (!bus.last_element) begin
            fin_sent  = 0;
            fin_delay = $urandom_range(0, 4);
        end else if (fin_en && !fin_sent) begin
            if (fin_delay == 0) begin
                bus.mgr_finished = 1'b1;
                fin_sent = 1;
                fin_cyc  = cyc;
            end else begin
                fin_delay--;
            end
        end
    endtask

    task automatic run_pass(bit do_pause, bit noise, bit fin_en);
        int budget;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        budget = 0;
        while (busy && budget < 400) begin
            respond(fin_en);
            pause = do_pause ? ($urandom_range(0, 2) == 0) : 1'b0;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clock); #1;
            budget++;
        end
        start = 1'b0;
        pause = 1'b0;
        bus.mgr_finished = 1'b0;
        check("pass_terminated", budget < 400, 1);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_in_en"}, bus.input_ram_enable, 0);
        check({tag, "_w_en"}, bus.weight_ram_enable, 0);
        check({tag, "_in_addr"}, bus.input_ram_address, 0);
        check({tag, "_w_addr"}, bus.weight_ram_address, 0);
        check({tag, "_next"}, bus.next_element, 0);
        check({tag, "_last"}, bus.last_element, 0);
        check({tag, "_mgr_clear"}, bus.mgr_clear, 0);
        check({tag, "_mgr_en"}, bus.mgr_en, 0);
    endtask

    initial begin
        int d0, c0, budget;
        bus.mgr_finished = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_idle("reset");
        @(posedge clock); #1 clear = 1'b0;

        timing_pass = 1;
        load_rams(); push_expect(1); run_pass(0, 0, 1);
        timing_pass = 0;

        for (int p = 0; p < 3; p++) begin
            load_rams(); push_expect(1); run_pass(1, 0, 1);
        end
        load_rams(); push_expect(1); run_pass(1, 1, 1);

        d0 = done_cnt;
        load_rams(); push_expect(0); run_pass(0, 0, 0);
        check("wb_cycles_before_timeout", le_cnt, WDOG);
        check("error_after_timeout", error, 1);
        check("no_done_on_timeout", done_cnt - d0, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("error_sticky", error, 1);

        load_rams(); push_expect(1); run_pass(0, 0, 1);

        load_rams(); push_expect(0);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (9) @(posedge clock);
        #1 clear = 1'b1;
        @(posedge clock); #1 clear = 1'b0;
        @(negedge clock);
        check_idle("after_clear");
        exp_q.delete();

        timing_pass = 1;
        load_rams(); push_expect(1); run_pass(0, 0, 1);
        timing_pass = 0;

        chain_mode = 1; chain_armed = 0;
        d0 = done_cnt; c0 = clr_cnt;
        load_rams(); push_expect(1); push_expect(1); push_expect(1);
        @(posedge clock); #1 start = 1'b1;
        budget = 0;
        while (done_cnt < d0 + 3 && budget < 800) begin
            respond(1);
            @(posedge clock); #1;
            budget++;
        end
        start = 1'b0;
        chain_mode = 0;
        bus.mgr_finished = 1'b0;
        check("chain_terminated", budget < 800, 1);
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("chain_done_count", done_cnt - d0, 3);
        check("chain_clear_count", clr_cnt - c0, 3);
        check("idle_after_chain", busy, 0);

        check("pairs_left", exp_q.size(), 0);
        check("sums_left", acc_q.size(), 0);
        check("total_done", done_cnt, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
